// File: rtl/load_store_sequencer_pkg.sv
// Shared types and helpers for the load/store sequencer.
//   lsu_size_e   : access size (byte / half / word)
//   lsu_state_e  : sequencer FSM states
//   decode_size  : maps the raw 2-bit request size onto lsu_size_e (2'b11 -> word)
//   beat_count   : number of byte beats for a size (1/2/4)
//   is_misaligned: natural-alignment check used by the optional misalignment trap
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    RESP
  } lsu_state_e;

  function automatic lsu_size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return LSU_BYTE;
      2'b01:   return LSU_HALF;
      default: return LSU_WORD;
    endcase
  endfunction

  function automatic logic [2:0] beat_count(input lsu_size_e size);
    case (size)
      LSU_BYTE: return 3'd1;
      LSU_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    case (size)
      LSU_BYTE: return 1'b0;
      LSU_HALF: return addr_lo[0];
      default:  return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_sequencer_if.sv
// Bundle of the sequencer's request/response and data-memory signals.
//   slave  : the sequencer's view (takes requests, returns responses, drives memory)
//   master : the environment's view (CPU datapath issuing requests plus the memory)
// Request:  req_valid_i, req_ready_o, req_we_i, req_size_i, req_unsigned_i,
//           req_addr_i, req_wdata_i
// Response: resp_valid_o, resp_rdata_o, resp_err_o
// Memory:   mem_wr_en_o, mem_addr_o, mem_wdata_o, mem_rdata_i
interface load_store_sequencer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_we_i;
  logic [1:0]               req_size_i;
  logic                     req_unsigned_i;
  logic [ADDRESS_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0]    req_wdata_i;
  logic                     resp_valid_o;
  logic [DATA_WIDTH-1:0]    resp_rdata_o;
  logic                     resp_err_o;
  logic                     mem_wr_en_o;
  logic [ADDRESS_WIDTH-1:0] mem_addr_o;
  logic [7:0]               mem_wdata_o;
  logic [7:0]               mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_wr_en_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_wr_en_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/load_store_sequencer_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
//   data        : assembled 32-bit data, byte lane 0 is the lowest address
//   size        : access size; lanes above the size are ignored
//   is_unsigned : 1 = zero-extend, 0 = sign-extend (no effect on word loads)
//   result      : extended 32-bit load value
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  always_comb begin
    result = data;
    case (size)
      LSU_BYTE: result = {{24{data[7]  & ~is_unsigned}}, data[7:0]};
      LSU_HALF: result = {{16{data[15] & ~is_unsigned}}, data[15:0]};
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Initiator side of the data-memory interface. Takes one load/store request at
// a time and serialises it into byte beats on a byte-addressed memory with a
// one-cycle synchronous read. Loads are assembled little-endian, extended, and
// returned with a single-cycle resp_valid_o pulse; stores pulse with zero data.
//
// Ports:
//   clk_i : clock, all logic on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : load_store_sequencer_if.slave (request, response and memory signals)
//
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests do
// no memory beats and respond in the next cycle with resp_err_o=1. Without it
// resp_err_o stays 0 and misaligned requests are serialised like any other.
module load_store_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  load_store_sequencer_if.slave         bus
);

  lsu_state_e               state;
  logic [1:0]               beat;
  logic                     we_q;
  lsu_size_e                size_q;
  logic                     unsigned_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [31:0]              rbuf;

  logic                     ready_q;
  logic                     resp_valid_q;
  logic [DATA_WIDTH-1:0]    resp_rdata_q;
  logic                     resp_err_q;
  logic                     mem_wr_en_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [7:0]               mem_wdata_q;

  lsu_size_e                req_size;
  logic                     trap;
  logic                     last_beat;
  logic [1:0]               next_beat;
  logic [1:0]               lane_prev;
  logic [31:0]              merged;
  logic [31:0]              extended;

  always_comb begin
    req_size  = decode_size(bus.req_size_i);
    next_beat = beat + 2'd1;
    lane_prev = beat - 2'd1;
    last_beat = ({1'b0, beat} == (beat_count(size_q) - 3'd1));
    // In DRAIN the final byte is still on mem_rdata_i; fold it into its lane
    // so the response can be formed without an extra cycle.
    merged    = rbuf;
    merged[{beat, 3'b000} +: 8] = bus.mem_rdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = is_misaligned(req_size, bus.req_addr_i[1:0]);
`else
    trap = 1'b0;
`endif
  end

  load_extend u_load_extend (
    .data        (merged),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (extended)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      beat         <= 2'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            we_q       <= bus.req_we_i;
            size_q     <= req_size;
            unsigned_q <= bus.req_unsigned_i;
            addr_q     <= bus.req_addr_i;
            wdata_q    <= bus.req_wdata_i;
            beat       <= 2'd0;
            ready_q    <= 1'b0;
            if (trap) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end else begin
              // Beat 0 is presented in the cycle right after acceptance.
              state       <= XFER;
              mem_wr_en_q <= bus.req_we_i;
              mem_addr_q  <= bus.req_addr_i;
              mem_wdata_q <= bus.req_wdata_i[7:0];
            end
          end
        end
        XFER: begin
          // The byte returned now belongs to the previous beat's address.
          if (!we_q && beat != 2'd0) begin
            rbuf[{lane_prev, 3'b000} +: 8] <= bus.mem_rdata_i;
          end
          if (last_beat) begin
            mem_wr_en_q <= 1'b0;
            if (we_q) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            beat        <= next_beat;
            mem_addr_q  <= addr_q + {{(ADDRESS_WIDTH-2){1'b0}}, next_beat};
            mem_wdata_q <= wdata_q[{next_beat, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= extended;
          resp_err_q   <= 1'b0;
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.mem_wr_en_o  = mem_wr_en_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;

endmodule
